pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decode-side and fetch-side signals of the program-counter sequencer.
// The master modport is the sequencer; the slave modport is the surrounding core.
interface pc_sequencer_if #(
    parameter int WORD_SIZE = 18,
    parameter int ADDR_SIZE = 16
);
    logic                 fetch_ready;
    logic [ADDR_SIZE-1:0] fetch_addr;
    logic                 fetch_valid;
    logic                 flush;
    logic                 dec_valid;
    logic                 dec_ready;
    logic [1:0]           dec_kind;
    logic [2:0]           dec_cond;
    logic [WORD_SIZE-1:0] dec_r0;
    logic [ADDR_SIZE-1:0] dec_target;
    logic [ADDR_SIZE-1:0] dec_pc;
    logic                 halted;
    logic [1:0]           err_code;

    modport master (
        input  fetch_ready, dec_valid, dec_kind, dec_cond, dec_r0, dec_target, dec_pc,
        output fetch_addr, fetch_valid, flush, dec_ready, halted, err_code
    );

    modport slave (
        output fetch_ready, dec_valid, dec_kind, dec_cond, dec_r0, dec_target, dec_pc,
        input  fetch_addr, fetch_valid, flush, dec_ready, halted, err_code
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch address, resolves branches/calls/returns
// against r0, keeps a small return stack and inserts a flush bubble after each redirect.
module pc_sequencer #(
    parameter int          WORD_SIZE    = 18,
    parameter int          ADDR_SIZE    = 16,
    parameter int          STACK_DEPTH  = 4,
    parameter int          FLUSH_CYCLES = 2,
    parameter int unsigned RESET_ADDR   = 0
) (
    input  logic           clock,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [ADDR_SIZE-1:0] RESET_PC   = ADDR_SIZE'(RESET_ADDR);
    localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [SP_W-1:0]      SP_FULL    = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_HALT} state_e;
    typedef enum logic [1:0] {K_NEXT, K_BRANCH, K_CALL, K_RET} kind_e;
    typedef enum logic [1:0] {E_NONE, E_OVERFLOW, E_UNDERFLOW} err_e;

    state_e               state, state_next;
    err_e                 err, err_next;
    logic [2:0]           cnt, cnt_next;
    logic [ADDR_SIZE-1:0] addr, addr_next;
    logic [SP_W-1:0]      sp, sp_next;
    logic [ADDR_SIZE-1:0] stack [STACK_DEPTH];
    logic                 push_en;
    logic                 taken;
    logic                 r0_neg, r0_zero;
    logic                 fetch_valid, dec_ready, flush, halted;
    kind_e                kind;
    logic [IDX_W-1:0]     push_idx, pop_idx;
    logic [ADDR_SIZE-1:0] ret_addr;

    assign kind     = kind_e'(bus.dec_kind);
    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - SP_W'(1));
    assign ret_addr = bus.dec_pc + ADDR_SIZE'(1);

    always_comb begin
        r0_neg  = bus.dec_r0[WORD_SIZE-1];
        r0_zero = (bus.dec_r0 == '0);
        taken   = 1'b0;
        case (bus.dec_cond)
            3'd0:    taken = r0_zero;
            3'd1:    taken = r0_neg;
            3'd2:    taken = !r0_neg && !r0_zero;
            3'd3:    taken = r0_neg || r0_zero;
            3'd4:    taken = !r0_neg;
            3'd5:    taken = !bus.dec_r0[0];
            3'd6:    taken = bus.dec_r0[0];
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        addr_next   = addr;
        sp_next     = sp;
        err_next    = err;
        push_en     = 1'b0;
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_FLUSH: begin
                flush = 1'b1;
                if (cnt <= 3'd1) state_next = ST_RUN;
                else             cnt_next   = cnt - 3'd1;
            end
            ST_RUN: begin
                fetch_valid = 1'b1;
                dec_ready   = 1'b1;
                if (bus.fetch_ready) addr_next = addr + ADDR_SIZE'(1);
                // A taken redirect overrides the sequential increment above.
                if (bus.dec_valid && taken) begin
                    case (kind)
                        K_BRANCH: begin
                            addr_next  = bus.dec_target;
                            state_next = ST_FLUSH;
                            cnt_next   = FLUSH_LOAD;
                        end
                        K_CALL: begin
                            if (sp == SP_FULL) begin
                                addr_next  = addr;
                                err_next   = E_OVERFLOW;
                                state_next = ST_HALT;
                            end else begin
                                push_en    = 1'b1;
                                sp_next    = sp + SP_W'(1);
                                addr_next  = bus.dec_target;
                                state_next = ST_FLUSH;
                                cnt_next   = FLUSH_LOAD;
                            end
                        end
                        K_RET: begin
                            if (sp == '0) begin
                                addr_next  = addr;
                                err_next   = E_UNDERFLOW;
                                state_next = ST_HALT;
                            end else begin
                                sp_next    = sp - SP_W'(1);
                                addr_next  = stack[pop_idx];
                                state_next = ST_FLUSH;
                                cnt_next   = FLUSH_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FLUSH;
            cnt   <= FLUSH_LOAD;
            addr  <= RESET_PC;
            sp    <= '0;
            err   <= E_NONE;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            addr  <= addr_next;
            sp    <= sp_next;
            err   <= err_next;
        end
    end

    // NOTE: stack storage has no reset; a zero stack pointer already marks every entry empty.
    always_ff @(posedge clock) begin
        if (push_en) stack[push_idx] <= ret_addr;
    end

    assign bus.fetch_addr  = addr;
    assign bus.fetch_valid = fetch_valid;
    assign bus.dec_ready   = dec_ready;
    assign bus.flush       = flush;
    assign bus.halted      = halted;
    assign bus.err_code    = err;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset bubble, sequential fetch, branch
// conditions, call/return stack, fault halts, address wrap and reset mid-flush.
module tb_pc_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if #(.WORD_SIZE(18), .ADDR_SIZE(16)) bus ();

    pc_sequencer #(
        .WORD_SIZE(18), .ADDR_SIZE(16), .STACK_DEPTH(4), .FLUSH_CYCLES(2), .RESET_ADDR(0)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        bus.fetch_ready = 1'b0;
        bus.dec_valid   = 1'b0;
        bus.dec_kind    = 2'd0;
        bus.dec_cond    = 3'd0;
        bus.dec_r0      = '0;
        bus.dec_target  = '0;
        bus.dec_pc      = '0;
    endtask

    // Waits (bounded) for the sequencer to leave its flush bubble.
    task automatic settle();
        int n = 0;
        while (bus.fetch_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (bus.fetch_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL settle_timeout fetch_valid=%b after %0d cycles, required 1", bus.fetch_valid, n);
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        settle();
    endtask

    // Presents one instruction for exactly one rising edge; returns on the following falling edge.
    task automatic issue(input logic [1:0] kind, input logic [2:0] cond, input logic [17:0] r0,
                         input logic [15:0] target, input logic [15:0] pc);
        bus.dec_kind   = kind;
        bus.dec_cond   = cond;
        bus.dec_r0     = r0;
        bus.dec_target = target;
        bus.dec_pc     = pc;
        bus.dec_valid  = 1'b1;
        @(negedge clock);
        bus.dec_valid  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clock);
        total++; if (bus.fetch_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", bus.fetch_addr); end
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL rst_flush got=%b exp=1", bus.flush); end
        total++; if (bus.fetch_valid !== 1'b0 || bus.dec_ready !== 1'b0) begin bad++; $display("FAIL rst_valid_ready got=%b%b exp=00", bus.fetch_valid, bus.dec_ready); end
        total++; if (bus.halted !== 1'b0 || bus.err_code !== 2'd0) begin bad++; $display("FAIL rst_err got=%b/%0d exp=0/0", bus.halted, bus.err_code); end
        reset_n = 1'b1;
        bus.fetch_ready = 1'b1;
        @(negedge clock);
        total++; if (bus.flush !== 1'b1 || bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_bubble2 flush=%b valid=%b exp=1/0", bus.flush, bus.fetch_valid); end
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.fetch_valid !== 1'b1 || bus.flush !== 1'b0 || bus.fetch_addr !== 16'(i)) begin
                bad++; $display("FAIL seq_fetch valid=%b flush=%b addr=%h exp=1/0/%h", bus.fetch_valid, bus.flush, bus.fetch_addr, 16'(i));
            end
            @(negedge clock);
        end
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.fetch_addr !== 16'h0004) begin bad++; $display("FAIL stall_hold got=%h exp=0004", bus.fetch_addr); end
            @(negedge clock);
        end
    endtask

    task automatic test_branch();
        bus.fetch_ready = 1'b1;
        issue(2'd1, 3'd2, 18'h00005, 16'h0100, 16'h0004);
        total++; if (bus.fetch_addr !== 16'h0100) begin bad++; $display("FAIL br_addr got=%h exp=0100", bus.fetch_addr); end
        total++; if (bus.flush !== 1'b1 || bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL br_bubble1 flush=%b valid=%b exp=1/0", bus.flush, bus.fetch_valid); end
        @(negedge clock);
        total++; if (bus.flush !== 1'b1 || bus.fetch_addr !== 16'h0100) begin bad++; $display("FAIL br_bubble2 flush=%b addr=%h exp=1/0100", bus.flush, bus.fetch_addr); end
        @(negedge clock);
        total++; if (bus.fetch_valid !== 1'b1 || bus.flush !== 1'b0 || bus.fetch_addr !== 16'h0100) begin bad++; $display("FAIL br_first valid=%b flush=%b addr=%h exp=1/0/0100", bus.fetch_valid, bus.flush, bus.fetch_addr); end
        @(negedge clock);
        total++; if (bus.fetch_addr !== 16'h0101) begin bad++; $display("FAIL br_second got=%h exp=0101", bus.fetch_addr); end
        // Not taken: zero bubble, sequential advance continues.
        issue(2'd1, 3'd2, 18'h00000, 16'h0300, 16'h0101);
        total++; if (bus.fetch_addr !== 16'h0102 || bus.flush !== 1'b0 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL br_not_taken addr=%h flush=%b exp=0102/0", bus.fetch_addr, bus.flush); end
        bus.fetch_ready = 1'b0;
        issue(2'd1, 3'd1, 18'h20000, 16'h0180, 16'h0102);
        total++; if (bus.fetch_addr !== 16'h0180 || bus.flush !== 1'b1) begin bad++; $display("FAIL br_neg_taken addr=%h flush=%b exp=0180/1", bus.fetch_addr, bus.flush); end
        settle();
    endtask

    task automatic test_conditions();
        logic [17:0] vals [6];
        logic [5:0]  exp_tbl [8];
        vals = '{18'h00000, 18'h00001, 18'h00002, 18'h1FFFF, 18'h20000, 18'h3FFFF};
        // Bit v of each row: whether condition c is taken for vals[v].
        exp_tbl = '{6'b000001, 6'b110000, 6'b001110, 6'b110001,
                    6'b001111, 6'b010101, 6'b101010, 6'b111111};
        bus.fetch_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int v = 0; v < 6; v++) begin
                issue(2'd1, 3'(c), vals[v], 16'h0400 + 16'(c * 8 + v), 16'h0000);
                total++;
                if (bus.flush !== exp_tbl[c][3'(v)]) begin
                    bad++; $display("FAIL cond%0d_r0_%h taken=%b exp=%b", c, vals[v], bus.flush, exp_tbl[c][3'(v)]);
                end
                if (bus.flush === 1'b1) settle();
            end
        end
    endtask

    task automatic test_call_ret();
        issue(2'd2, 3'd7, 18'h0, 16'h0200, 16'h0010);
        total++; if (bus.fetch_addr !== 16'h0200 || bus.flush !== 1'b1) begin bad++; $display("FAIL call_addr addr=%h flush=%b exp=0200/1", bus.fetch_addr, bus.flush); end
        settle();
        issue(2'd3, 3'd7, 18'h0, 16'h0000, 16'h0200);
        total++; if (bus.fetch_addr !== 16'h0011 || bus.flush !== 1'b1) begin bad++; $display("FAIL ret_addr addr=%h flush=%b exp=0011/1", bus.fetch_addr, bus.flush); end
        settle();
        total++; if (bus.fetch_addr !== 16'h0011 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL ret_resume addr=%h exp=0011", bus.fetch_addr); end
    endtask

    task automatic push_four();
        for (int i = 0; i < 4; i++) begin
            issue(2'd2, 3'd7, 18'h0, 16'h1000 + 16'(i * 'h100), 16'h0020 + 16'(i * 'h10));
            total++; if (bus.fetch_addr !== 16'h1000 + 16'(i * 'h100)) begin bad++; $display("FAIL nest_call%0d got=%h exp=%h", i, bus.fetch_addr, 16'h1000 + 16'(i * 'h100)); end
            settle();
        end
    endtask

    task automatic test_nested();
        push_four();
        for (int i = 3; i >= 0; i--) begin
            issue(2'd3, 3'd7, 18'h0, 16'h0000, 16'h0000);
            total++; if (bus.fetch_addr !== 16'h0021 + 16'(i * 'h10)) begin bad++; $display("FAIL nest_ret%0d got=%h exp=%h", i, bus.fetch_addr, 16'h0021 + 16'(i * 'h10)); end
            settle();
        end
    endtask

    task automatic test_overflow();
        push_four();
        bus.fetch_ready = 1'b1;
        issue(2'd2, 3'd7, 18'h0, 16'h2000, 16'h0060);
        total++; if (bus.halted !== 1'b1 || bus.err_code !== 2'd1) begin bad++; $display("FAIL ovf_err halted=%b err=%0d exp=1/1", bus.halted, bus.err_code); end
        total++; if (bus.fetch_valid !== 1'b0 || bus.dec_ready !== 1'b0 || bus.flush !== 1'b0) begin bad++; $display("FAIL ovf_outputs valid=%b ready=%b flush=%b exp=000", bus.fetch_valid, bus.dec_ready, bus.flush); end
        total++; if (bus.fetch_addr !== 16'h1300) begin bad++; $display("FAIL ovf_addr_hold got=%h exp=1300", bus.fetch_addr); end
        bus.dec_valid = 1'b1;
        bus.dec_kind  = 2'd3;
        repeat (3) @(negedge clock);
        bus.dec_valid = 1'b0;
        bus.fetch_ready = 1'b0;
        total++; if (bus.halted !== 1'b1 || bus.dec_ready !== 1'b0 || bus.err_code !== 2'd1 || bus.fetch_addr !== 16'h1300) begin
            bad++; $display("FAIL ovf_sticky halted=%b ready=%b err=%0d addr=%h exp=1/0/1/1300", bus.halted, bus.dec_ready, bus.err_code, bus.fetch_addr);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        issue(2'd3, 3'd0, 18'h00001, 16'h0000, 16'h0000);
        total++; if (bus.halted !== 1'b0 || bus.flush !== 1'b0 || bus.fetch_valid !== 1'b1) begin bad++; $display("FAIL ret_not_taken halted=%b flush=%b exp=0/0", bus.halted, bus.flush); end
        issue(2'd3, 3'd7, 18'h00000, 16'h0000, 16'h0000);
        total++; if (bus.halted !== 1'b1 || bus.err_code !== 2'd2 || bus.fetch_valid !== 1'b0) begin bad++; $display("FAIL unf_err halted=%b err=%0d valid=%b exp=1/2/0", bus.halted, bus.err_code, bus.fetch_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        issue(2'd1, 3'd7, 18'h0, 16'hFFFF, 16'h0000);
        settle();
        total++; if (bus.fetch_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", bus.fetch_addr); end
        bus.fetch_ready = 1'b1;
        @(negedge clock);
        bus.fetch_ready = 1'b0;
        total++; if (bus.fetch_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr got=%h exp=0000", bus.fetch_addr); end
        issue(2'd2, 3'd7, 18'h0, 16'h0050, 16'hFFFF);
        settle();
        issue(2'd3, 3'd7, 18'h0, 16'h0000, 16'h0050);
        total++; if (bus.fetch_addr !== 16'h0000 || bus.flush !== 1'b1) begin bad++; $display("FAIL wrap_push addr=%h flush=%b exp=0000/1", bus.fetch_addr, bus.flush); end
        settle();
    endtask

    task automatic test_reset_mid_flush();
        issue(2'd2, 3'd7, 18'h0, 16'h0200, 16'h0010);
        total++; if (bus.flush !== 1'b1 || bus.fetch_addr !== 16'h0200) begin bad++; $display("FAIL mid_call flush=%b addr=%h exp=1/0200", bus.flush, bus.fetch_addr); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus.fetch_addr !== 16'h0000 || bus.halted !== 1'b0) begin bad++; $display("FAIL mid_rst_async addr=%h halted=%b exp=0000/0", bus.fetch_addr, bus.halted); end
        @(negedge clock);
        reset_n = 1'b1;
        settle();
        total++; if (bus.fetch_addr !== 16'h0000) begin bad++; $display("FAIL mid_rst_addr got=%h exp=0000", bus.fetch_addr); end
        issue(2'd3, 3'd7, 18'h0, 16'h0000, 16'h0000);
        total++; if (bus.halted !== 1'b1 || bus.err_code !== 2'd2) begin bad++; $display("FAIL mid_rst_stack halted=%b err=%0d exp=1/2", bus.halted, bus.err_code); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_conditions();
        test_call_ret();
        test_nested();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
